// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: two request masters plus the shared memory port
interface mem_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int MW = DATA_W / 8;
  logic              m0_req, m0_we, m0_done, m0_err, m0_stall;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata, m0_rdata;
  logic [MW-1:0]     m0_mask;
  logic              m1_req, m1_we, m1_done, m1_err, m1_stall;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata, m1_rdata;
  logic [MW-1:0]     m1_mask;
  logic              mem_req, mem_we, mem_cs, mem_ack;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic [MW-1:0]     mem_mask;
  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata, m0_mask,
    output m0_rdata, m0_done, m0_err, m0_stall,
    input  m1_req, m1_we, m1_addr, m1_wdata, m1_mask,
    output m1_rdata, m1_done, m1_err, m1_stall,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_mask, mem_cs,
    input  mem_ack, mem_rdata
  );
  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata, m0_mask,
    input  m0_rdata, m0_done, m0_err, m0_stall,
    output m1_req, m1_we, m1_addr, m1_wdata, m1_mask,
    input  m1_rdata, m1_done, m1_err, m1_stall,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_mask, mem_cs,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin sharing of one memory port between two masters
module mem_bus_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input logic clk,
  input logic rst_n,
  mem_bus_arbiter_if.slave bus
);
  localparam int MW = DATA_W / 8;
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TLAST = CW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t            state_q, state_d;
  logic              gnt_q, gnt_d, last_q, last_d, we_q, we_d;
  logic              err0_q, err0_d, err1_q, err1_d, fire;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata0_q, rdata0_d, rdata1_q, rdata1_d, rdata_n;
  logic [MW-1:0]     mask_q, mask_d;
  assign fire    = (TIMEOUT != 0) && (cnt_q == TLAST);
  assign rdata_n = bus.mem_ack ? bus.mem_rdata : '0;
  assign bus.mem_req   = state_q == BUSY;
  assign bus.mem_cs    = state_q == BUSY;
  assign bus.mem_we    = (state_q == BUSY) & we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_mask  = mask_q;
  assign bus.m0_done   = (state_q == RESP) & ~gnt_q;
  assign bus.m1_done   = (state_q == RESP) & gnt_q;
  assign bus.m0_err    = err0_q;
  assign bus.m1_err    = err1_q;
  assign bus.m0_rdata  = rdata0_q;
  assign bus.m1_rdata  = rdata1_q;
  assign bus.m0_stall  = rst_n & bus.m0_req & ~bus.m0_done;
  assign bus.m1_stall  = rst_n & bus.m1_req & ~bus.m1_done;
  // State and captured-request registers; last grant resets to m1 so m0 wins the first tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      gnt_q    <= 1'b0;
      last_q   <= 1'b1;
      we_q     <= 1'b0;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      mask_q   <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      err0_q   <= 1'b0;
      err1_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      last_q   <= last_d;
      we_q     <= we_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      mask_q   <= mask_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      err0_q   <= err0_d;
      err1_q   <= err1_d;
    end
  end
  // Arbitrate in IDLE, wait for ack or timeout in BUSY, pulse done in RESP; ack beats timeout
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    last_d   = last_q;
    we_d     = we_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    mask_d   = mask_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    err0_d   = err0_q;
    err1_d   = err1_q;
    case (state_q)
      IDLE: if (bus.m0_req | bus.m1_req) begin
        gnt_d   = (bus.m0_req & bus.m1_req) ? ~last_q : bus.m1_req;
        last_d  = gnt_d;
        we_d    = gnt_d ? bus.m1_we    : bus.m0_we;
        addr_d  = gnt_d ? bus.m1_addr  : bus.m0_addr;
        wdata_d = gnt_d ? bus.m1_wdata : bus.m0_wdata;
        mask_d  = gnt_d ? bus.m1_mask  : bus.m0_mask;
        cnt_d   = '0;
        state_d = BUSY;
      end
      BUSY: if (bus.mem_ack | fire) begin
        rdata0_d = gnt_q ? rdata0_q : rdata_n;
        rdata1_d = gnt_q ? rdata_n  : rdata1_q;
        err0_d   = gnt_q ? err0_q : ~bus.mem_ack;
        err1_d   = gnt_q ? ~bus.mem_ack : err1_q;
        state_d  = RESP;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed stimulus with a done-driven scoreboard
module tb_mem_bus_arbiter;
  typedef struct {bit m; logic [31:0] rdata; bit err;} exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  exp_t q[$];
  mem_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus();
  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic set_m(input bit m, input bit req, input bit we, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] mk);
    if (m) begin
      bus.m1_req = req; bus.m1_we = we; bus.m1_addr = a; bus.m1_wdata = wd; bus.m1_mask = mk;
    end else begin
      bus.m0_req = req; bus.m0_we = we; bus.m0_addr = a; bus.m0_wdata = wd; bus.m0_mask = mk;
    end
  endtask
  task automatic wait_grant();
    for (int i = 0; i < 8 && !bus.mem_req; i++) tick();
    chk("grant", 32'(bus.mem_req), 32'd1);
  endtask
  // d = number of BUSY cycles before the ack cycle; d < 0 means never ack
  task automatic access(input bit m, input bit we, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] mk, input int d, input logic [31:0] rd);
    int n;
    exp_t e;
    e.m = m; e.rdata = d < 0 ? 32'd0 : rd; e.err = d < 0;
    q.push_back(e);
    set_m(m, 1'b1, we, a, wd, mk);
    wait_grant();
    chk("mem_addr", bus.mem_addr, a);
    chk("mem_we", 32'(bus.mem_we), 32'(we));
    chk("mem_wdata", bus.mem_wdata, wd);
    chk("mem_mask", 32'(bus.mem_mask), 32'(mk));
    chk("mem_cs", 32'(bus.mem_cs), 32'd1);
    if (d < 0) begin
      n = 0;
      while (bus.mem_req && n < 20) begin
        n++;
        chk("stall_busy", 32'(m ? bus.m1_stall : bus.m0_stall), 32'd1);
        tick();
      end
      chk("timeout_len", n, 32'd4);
    end else begin
      for (int i = 0; i < d; i++) begin
        chk("stall_busy", 32'(m ? bus.m1_stall : bus.m0_stall), 32'd1);
        tick();
        chk("req_held", 32'(bus.mem_req), 32'd1);
      end
      bus.mem_ack = 1'b1; bus.mem_rdata = rd;
      tick();
      bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;
      chk("req_drop", 32'(bus.mem_req), 32'd0);
    end
    chk("done", 32'(m ? bus.m1_done : bus.m0_done), 32'd1);
    chk("stall_done", 32'(m ? bus.m1_stall : bus.m0_stall), 32'd0);
    set_m(m, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    tick();
    chk("done_pulse", 32'(m ? bus.m1_done : bus.m0_done), 32'd0);
  endtask
  // Scoreboard monitor: every done pulse must match the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && (bus.m0_done || bus.m1_done)) begin
      chk("one_done", 32'(bus.m0_done & bus.m1_done), 32'd0);
      if (q.size() == 0) begin
        chk("unexpected_done", 32'(bus.m1_done), 32'd2);
      end else begin
        e = q.pop_front();
        chk("sb_master", 32'(bus.m1_done), 32'(e.m));
        chk("sb_rdata", e.m ? bus.m1_rdata : bus.m0_rdata, e.rdata);
        chk("sb_err", 32'(e.m ? bus.m1_err : bus.m0_err), 32'(e.err));
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    set_m(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    set_m(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;
    tick();
    tick();
    chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_mem_cs", 32'(bus.mem_cs), 32'd0);
    chk("rst_m0_done", 32'(bus.m0_done), 32'd0);
    chk("rst_m1_done", 32'(bus.m1_done), 32'd0);
    chk("rst_m0_rdata", bus.m0_rdata, 32'h0);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    rst_n = 1'b1;
    tick();
    chk("idle_no_req", 32'(bus.mem_req), 32'd0);
    access(1'b0, 1'b0, 32'h100, 32'h0, 4'hF, 1, 32'hDEADBEEF);
    access(1'b0, 1'b1, 32'h204, 32'h12345678, 4'b1100, 0, 32'h0BADF00D);
    access(1'b0, 1'b0, 32'h300, 32'h0, 4'hF, -1, 32'h0);
    access(1'b0, 1'b0, 32'h304, 32'h0, 4'hF, 0, 32'h11112222);
    chk("m0_err_cleared", 32'(bus.m0_err), 32'd0);
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'hFFFFFFFF;
    tick();
    chk("stray_no_m0_done", 32'(bus.m0_done), 32'd0);
    chk("stray_no_m1_done", 32'(bus.m1_done), 32'd0);
    tick();
    bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;
    chk("stray_no_req", 32'(bus.mem_req), 32'd0);
    access(1'b1, 1'b0, 32'h400, 32'h0, 4'hF, 0, 32'hA5A5A5A5);
    chk("m0_rdata_kept", bus.m0_rdata, 32'h11112222);
    set_m(1'b0, 1'b1, 1'b0, 32'h500, 32'h0, 4'hF);
    wait_grant();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("arst_mem_cs", 32'(bus.mem_cs), 32'd0);
    chk("arst_m0_stall", 32'(bus.m0_stall), 32'd0);
    chk("arst_m1_rdata", bus.m1_rdata, 32'h0);
    chk("arst_done", 32'(bus.m0_done | bus.m1_done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    access(1'b0, 1'b0, 32'h500, 32'h0, 4'hF, 0, 32'h600D600D);
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    set_m(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 4'hF);
    set_m(1'b1, 1'b1, 1'b0, 32'h20, 32'h0, 4'hF);
    for (int i = 0; i < 4; i++) begin
      exp_t e;
      e.m = i[0]; e.rdata = 32'hC0DE0000 + i; e.err = 1'b0;
      q.push_back(e);
    end
    for (int i = 0; i < 4; i++) begin
      wait_grant();
      chk("rr_addr", bus.mem_addr, i[0] ? 32'h20 : 32'h10);
      chk("rr_other_stall", 32'(i[0] ? bus.m0_stall : bus.m1_stall), 32'd1);
      bus.mem_ack = 1'b1; bus.mem_rdata = 32'hC0DE0000 + i;
      tick();
      bus.mem_ack = 1'b0;
      chk("rr_done", 32'(i[0] ? bus.m1_done : bus.m0_done), 32'd1);
      if (i == 3) begin
        set_m(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        set_m(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      end
      tick();
    end
    tick();
    tick();
    chk("end_idle", 32'(bus.mem_req), 32'd0);
    chk("sb_empty", q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
